// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and helpers for the asynchronous serial blocks
package serial_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } tx_state_t;

    // Wide enough to count up to 9 data bits or 2 stop bits
    localparam int CNT_W = 4;

    // Bit-timer width; never narrower than one bit
    function automatic int timer_width(input int clk_div);
        return (clk_div > 2) ? $clog2(clk_div) : 1;
    endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// rtl/serial_bit_timer.sv - per-bit down-counter flagging the last cycle of a serial bit
module serial_bit_timer
    import serial_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic bit_end
);

    localparam int TW = timer_width(CLK_DIV);
    localparam logic [TW-1:0] RELOAD = TW'(CLK_DIV - 1);

    logic [TW-1:0] count;

    // Reload at the start of every bit, then count down and rest at zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (restart) begin
            count <= RELOAD;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign bit_end = (count == '0);

endmodule

// File: rtl/serial_tx_frame.sv
// rtl/serial_tx_frame.sv - parametrised async-serial transmitter with one-word holding buffer
module serial_tx_frame
    import serial_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int CLK_DIV   = 16,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 serialOut,
    output logic                 busy
);

    if (DATA_BITS < 5 || DATA_BITS > 9 || CLK_DIV < 2 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
        $error("serial_tx_frame: illegal parameter combination");
    end

    localparam parity_t PAR_MODE = parity_t'(PARITY);
    localparam logic    PAR_EN   = (PAR_MODE != NONE);

    tx_state_t            state, state_n;
    logic [DATA_BITS-1:0] hold, shifter;
    logic                 hold_full, par_bit;
    logic [CNT_W-1:0]     bit_cnt, bit_cnt_n;
    logic                 bit_end, restart, load, shift, line_n, accept;

    assign accept   = tx_valid && !hold_full;
    assign tx_ready = ~hold_full;
    assign busy     = (state != IDLE) || hold_full;
    // In IDLE the timer restarts only when a frame begins; elsewhere on every bit boundary
    assign restart  = (state == IDLE) ? hold_full : bit_end;

    serial_bit_timer #(
        .CLK_DIV(CLK_DIV)
    ) u_bit_timer (
        .clk    (clk),
        .reset  (reset),
        .restart(restart),
        .bit_end(bit_end)
    );

    // Next state, load/shift strobes and the TxD level for the next cycle
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        load      = 1'b0;
        shift     = 1'b0;
        line_n    = 1'b1;
        case (state)
            IDLE: begin
                if (hold_full) begin
                    state_n = START;
                    load    = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift = 1'b1;
                    if (bit_cnt == CNT_W'(DATA_BITS - 1)) begin
                        state_n   = PAR_EN ? PAR : STOP;
                        bit_cnt_n = '0;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            PAR: begin
                if (bit_end) begin
                    state_n   = STOP;
                    bit_cnt_n = '0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_cnt == CNT_W'(STOP_BITS - 1)) begin
                        bit_cnt_n = '0;
                        // A waiting word starts immediately: no idle gap between frames
                        if (hold_full) begin
                            state_n = START;
                            load    = 1'b1;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        case (state_n)
            START:   line_n = 1'b0;
            DATA:    line_n = shift ? shifter[1] : shifter[0];
            PAR:     line_n = par_bit;
            default: line_n = 1'b1;
        endcase
    end

    // Holding buffer: filled by the handshake, emptied when the shifter loads
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (accept) begin
            hold      <= tx_data;
            hold_full <= 1'b1;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    // Frame state, shifter, latched parity and the registered TxD line
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shifter   <= '0;
            par_bit   <= 1'b0;
            serialOut <= 1'b1;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            serialOut <= line_n;
            if (load) begin
                shifter <= hold;
                par_bit <= (PAR_MODE == ODD) ? ~^hold : ^hold;
            end else if (shift) begin
                shifter <= shifter >> 1;
            end
        end
    end

endmodule

// File: doc/serial_tx_frame.md
# serial_tx_frame

Parametrised asynchronous-serial transmitter, the successor to the fixed 8-N-1 transmitter. It has a configurable word length, parity, stop-bit count and internal bit-rate divider. A one-word holding buffer with a valid/ready handshake lets the CPU-side bus stream frames back-to-back with no idle gap. It sits between the CPU I/O port register and the board's serial TxD pin.

## Interface
- `DATA_BITS`, default 8: word length, legal range 5..9.
- `CLK_DIV`, default 16: `clk` cycles per serial bit, legal range ≥2.
- `PARITY`, default 0: 0 none, 1 even, 2 odd.
- `STOP_BITS`, default 1: 1 or 2.
- `clk` input, 1: single system clock, all state on rising edge.
- `reset` input, 1: asynchronous, active-low.
- `tx_data` input, DATA_BITS: word to send, LSB first.
- `tx_valid` input, 1: `tx_data` is offered.
- `tx_ready` output, 1: holding buffer empty; the word is accepted when `tx_valid && tx_ready` at a rising edge.
- `serialOut` output, 1: TxD line, idle high.
- `busy` output, 1: a frame is on the line or the buffer is full.

## Operation
- Reset values (async, while `reset`=0):
  - `serialOut`=1, `tx_ready`=1, `busy`=0.
  - FSM=IDLE, bit timer=0, buffer empty.
- Holding buffer: a DATA_BITS register plus `hold_full` flag. `tx_ready` = ~`hold_full`, driven directly from the flop.
- FSM states: IDLE, START, DATA, PAR, STOP.
- Bit timer: loads CLK_DIV-1 on each bit entry and decrements. `bit_end` is asserted when it reaches 0.
- IDLE:
  - If `hold_full`: load shifter from the buffer, clear `hold_full`, go to START.
  - Otherwise drive 1.
- START: drive 0 for one bit, then go to DATA.
- DATA: drive shifter[0] and shift right on each `bit_end`. After DATA_BITS bits, go to PAR if PARITY≠0, else STOP.
- PAR: drive the parity bit for one bit, then go to STOP.
  - Even parity: XOR of the word.
  - Odd parity: inverted XOR of the word.
  - Parity is computed at shifter load, not from the shifting register.
- STOP: drive 1 for STOP_BITS bits. At the final `bit_end`:
  - If `hold_full`: load the buffer and go directly to START in the same edge.
  - Otherwise go to IDLE.
- Simultaneous events:
  - An accept and a buffer→shifter transfer never coincide, because `tx_ready` is 0 while the buffer is full.
  - An accept during any frame state fills the buffer only; the current frame is unaffected.
- Reset asserted mid-frame: the line returns to 1 immediately (async) and the pending buffered word is discarded.
- `serialOut` is a flop output: no combinational path from any input.

## Timing
- Accept at edge N → `hold_full`=1 and `tx_ready`=0 for one cycle (from IDLE).
- At edge N+1 the transfer occurs and `serialOut` falls (start bit). `tx_ready` returns to 1 after edge N+1.
- Every bit lasts exactly CLK_DIV cycles.
- Frame length = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLK_DIV cycles.
- Back-to-back: the next start bit begins on the edge immediately after the last stop-bit cycle. There are zero idle cycles between frames.
- `busy` = (FSM≠IDLE) | `hold_full`, registered-equivalent. It deasserts the cycle the FSM enters IDLE with the buffer empty.

## Structure
- Shared package `serial_pkg`:
  - `parity_t` enum (NONE, EVEN, ODD).
  - `tx_state_t` enum.
  - Width helper `$clog2(CLK_DIV)` for the timer.
- One sub-module: `serial_bit_timer`.
  - Parameter CLK_DIV.
  - Inputs `clk`, `reset`, `restart`.
  - Output `bit_end`.
  - Reused later by the receiver.
- Parameter legality is checked with an elaboration-time assertion.

## Test plan
- Default parameters, send 0x55 → line shows a 0 start bit, then 1,0,1,0,1,0,1,0, then a 1 stop bit. Each bit is 16 cycles; 160 cycles total; `busy` drops at cycle 161.
- DATA_BITS=7, PARITY=EVEN, send 0x03 (two ones) → parity bit 0. Same test with PARITY=ODD → parity bit 1. Frame is 10 bits.
- STOP_BITS=2, two words offered back-to-back (the second on the cycle `tx_ready` returns) → second start bit begins exactly 11×CLK_DIV cycles after the first, with no idle cycle.
- Hold `tx_valid` high with a third word while the buffer is full → `tx_ready`=0. The word is accepted only after the second frame's transfer, and all three frames appear in order.
- Assert `reset` mid-DATA → `serialOut`=1 and `tx_ready`=1 asynchronously. After release, the next word transmits cleanly from IDLE.
- CLK_DIV=2, DATA_BITS=9, send 0x1FF → start bit plus nine 1s plus stop bit, each 2 cycles wide.
